// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//  - BCD digit width and the add-3 threshold used by double dabble
//  - FSM state encoding (IDLE / SHIFT / DONE)
//  - add3_if_ge5: the per-digit correction applied before every shift
package bin2bcd_pkg;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_SHIFT = 2'd1;
   localparam state_t S_DONE  = 2'd2;

   // A digit of 5..9 becomes 8..12, so the following left shift carries
   // exactly one into the next digit. Values above 9 never occur in a
   // well-formed digit; the add simply wraps within 4 bits.
   function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
      return (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj: combinational "if >= 5 then add 3" for one BCD digit.
// Ports:
//  digit_in   in   4   current digit of the BCD shift register
//  digit_out  out  4   corrected digit, ready to be shifted left
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_in,
   output logic [BCD_DIGIT_W-1:0] digit_out
);

   assign digit_out = add3_if_ge5(digit_in);

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 (double dabble) binary-to-BCD
// converter, one input bit per clock.
// Handshake: a conversion is accepted on a rising edge where start=1 and
// ready=1 (ready is high in IDLE and DONE). bin_in is sampled on that edge
// only. done is a one-cycle pulse; bcd_out/overflow become valid in that
// cycle and are held until the next done.
// Ports:
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  start      in   1            conversion request
//  bin_in     in   BIN_W        unsigned operand
//  ready      out  1            can accept start (IDLE or DONE)
//  busy       out  1            conversion in progress (SHIFT)
//  done       out  1            result pulse
//  bcd_out    out  4*DIGITS     packed BCD, digit 0 in bits [3:0]
//  overflow   out  1            value did not fit in DIGITS digits
//  dbg_state  out  2            current FSM state, for observation only
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin_in,
   output logic                          ready,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                          overflow,
   output state_t                        dbg_state
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [BIN_W-1:0]   bin_reg;
   logic [BCD_W-1:0]   bcd_reg;
   logic               ovf_reg;

   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_next;
   logic               ovf_shift_bit;
   logic               accept;
   logic               last_shift;

   // Per-digit add-3 correction on the current BCD register.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (bcd_reg[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // Shift the corrected digits left by one, pulling in the binary MSB.
   // Whatever falls out of the top digit means the value needs more digits
   // than we have; it is accumulated into the sticky overflow flag.
   assign bcd_next      = {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
   assign ovf_shift_bit = bcd_adj[BCD_W-1];

   assign ready      = (state == S_IDLE) || (state == S_DONE);
   assign busy       = (state == S_SHIFT);
   assign accept     = start && ready;
   assign last_shift = busy && (count == LAST_CNT);
   assign dbg_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         count    <= '0;
         bin_reg  <= '0;
         bcd_reg  <= '0;
         ovf_reg  <= 1'b0;
         bcd_out  <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_SHIFT) begin
            bcd_reg <= bcd_next;
            bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
            ovf_reg <= ovf_reg | ovf_shift_bit;
            count   <= count + 1'b1;
            if (last_shift) begin
               state    <= S_DONE;
               bcd_out  <= bcd_next;
               overflow <= ovf_reg | ovf_shift_bit;
               done     <= 1'b1;
            end
         end else if (accept) begin
            // Entered from IDLE or straight out of DONE (back-to-back).
            state   <= S_SHIFT;
            bin_reg <= bin_in;
            bcd_reg <= '0;
            ovf_reg <= 1'b0;
            count   <= '0;
         end else begin
            state <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq. Three instances: BIN_W=8/DIGITS=3 (main),
// BIN_W=8/DIGITS=2 (overflow cases) and BIN_W=5/DIGITS=2 (legacy range).
// Expected results come from an arithmetic model (div/mod by 10) and are
// queued when a conversion is started, then popped on each done pulse.
module tb_bin2bcd_seq;
   import bin2bcd_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        start0, start1, start2;
   logic [7:0]  bin0, bin1;
   logic [4:0]  bin2;
   logic        ready0, busy0, done0, ovf0;
   logic        ready1, busy1, done1, ovf1;
   logic        ready2, busy2, done2, ovf2;
   logic [11:0] bcd0;
   logic [7:0]  bcd1, bcd2;
   state_t      st0, st1, st2;

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .bin_in(bin0),
      .ready(ready0), .busy(busy0), .done(done0), .bcd_out(bcd0),
      .overflow(ovf0), .dbg_state(st0)
   );

   bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_d2 (
      .clk(clk), .rst_n(rst_n), .start(start1), .bin_in(bin1),
      .ready(ready1), .busy(busy1), .done(done1), .bcd_out(bcd1),
      .overflow(ovf1), .dbg_state(st1)
   );

   bin2bcd_seq #(.BIN_W(5), .DIGITS(2)) u_dut_w5 (
      .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin2),
      .ready(ready2), .busy(busy2), .done(done2), .bcd_out(bcd2),
      .overflow(ovf2), .dbg_state(st2)
   );

   // ---------------- scoreboard ----------------
   // Entry layout: bit 12 = overflow, bits [11:0] = packed BCD.
   logic [12:0] exp_q0[$];
   logic [12:0] exp_q1[$];
   logic [12:0] exp_q2[$];
   int n_cmp = 0;
   int n_err = 0;
   int push_cnt[3] = '{0, 0, 0};
   int done_cnt[3] = '{0, 0, 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [12:0] model(input int v, input int digits);
      int pow;
      int r;
      logic [12:0] res;
      pow = 1;
      res = '0;
      for (int i = 0; i < digits; i++) pow = pow * 10;
      r = v % pow;
      for (int i = 0; i < digits; i++) begin
         res[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      res[12] = (v >= pow);
      return res;
   endfunction

   // Monitors: sample at the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [12:0] e;
      if (done0) begin
         done_cnt[0]++;
         check("d3_q_nonempty", 32'(exp_q0.size() != 0), 32'd1);
         if (exp_q0.size() != 0) begin
            e = exp_q0.pop_front();
            check("d3_bcd", 32'(bcd0), 32'(e[11:0]));
            check("d3_ovf", 32'(ovf0), 32'(e[12]));
         end
      end
      if (done1) begin
         done_cnt[1]++;
         check("d2_q_nonempty", 32'(exp_q1.size() != 0), 32'd1);
         if (exp_q1.size() != 0) begin
            e = exp_q1.pop_front();
            check("d2_bcd", 32'(bcd1), 32'(e[7:0]));
            check("d2_ovf", 32'(ovf1), 32'(e[12]));
         end
      end
      if (done2) begin
         done_cnt[2]++;
         check("w5_q_nonempty", 32'(exp_q2.size() != 0), 32'd1);
         if (exp_q2.size() != 0) begin
            e = exp_q2.pop_front();
            check("w5_bcd", 32'(bcd2), 32'(e[7:0]));
            check("w5_ovf", 32'(ovf2), 32'(e[12]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic done_of(input int which);
      case (which)
         0:       return done0;
         1:       return done1;
         default: return done2;
      endcase
   endfunction

   task automatic push_exp(input int which, input int v);
      case (which)
         0:       exp_q0.push_back(model(v, 3));
         1:       exp_q1.push_back(model(v, 2));
         default: exp_q2.push_back(model(v, 2));
      endcase
      push_cnt[which]++;
   endtask

   task automatic set_start(input int which, input logic s, input int v);
      case (which)
         0:       begin start0 = s; bin0 = 8'(v); end
         1:       begin start1 = s; bin1 = 8'(v); end
         default: begin start2 = s; bin2 = 5'(v); end
      endcase
   endtask

   // One conversion: start for one cycle, scramble bin_in while busy,
   // then count edges until done (bounded) and check the latency.
   task automatic run_conv(input int which, input int v);
      int lat;
      int exp_lat;
      exp_lat = (which == 2) ? 5 : 8;
      @(posedge clk); #1;
      set_start(which, 1'b1, v);
      push_exp(which, v);
      @(posedge clk); #1;
      set_start(which, 1'b0, int'($urandom_range(0, 255)));
      lat = 0;
      while (!done_of(which) && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      bin0 = '0; bin1 = '0; bin2 = '0;

      // Reset state
      #1;
      check("rst_bcd", 32'(bcd0), 32'd0);
      check("rst_ovf", 32'(ovf0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_ready", 32'(ready0), 32'd1);
      check("rst_state", 32'(st0), 32'(S_IDLE));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // T1: 255 -> 255, no overflow
      run_conv(0, 255);
      check("t1_bcd", 32'(bcd0), 32'h255);
      check("t1_ovf", 32'(ovf0), 32'd0);
      check("t1_state", 32'(st0), 32'(S_DONE));

      // T2: boundaries and exhaustive sweep
      run_conv(0, 0);
      check("t2_zero", 32'(bcd0), 32'h000);
      run_conv(0, 99);
      check("t2_99", 32'(bcd0), 32'h099);
      run_conv(0, 100);
      check("t2_100", 32'(bcd0), 32'h100);
      for (int i = 0; i < 256; i++) run_conv(0, i);

      // T3: start during busy with a different operand is ignored
      @(posedge clk); #1;
      set_start(0, 1'b1, 200);
      push_exp(0, 200);
      @(posedge clk); #1;
      set_start(0, 1'b0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t3_busy", 32'(busy0), 32'd1);
      check("t3_ready", 32'(ready0), 32'd0);
      set_start(0, 1'b1, 17);
      @(posedge clk); #1;
      set_start(0, 1'b0, 17);
      repeat (15) @(posedge clk);
      #1;
      check("t3_bcd", 32'(bcd0), 32'h200);
      check("t3_single_done", 32'(done_cnt[0]), 32'(push_cnt[0]));

      // T4: DIGITS=2 overflow then recovery
      run_conv(1, 100);
      check("t4_bcd", 32'(bcd1), 32'h00);
      check("t4_ovf", 32'(ovf1), 32'd1);
      run_conv(1, 42);
      check("t4_bcd2", 32'(bcd1), 32'h42);
      check("t4_ovf2", 32'(ovf1), 32'd0);
      for (int i = 0; i < 20; i++) run_conv(1, int'($urandom_range(0, 255)));

      // T5: reset in the middle of a conversion
      run_conv(0, 123);
      @(posedge clk); #1;
      set_start(0, 1'b1, 200);
      push_exp(0, 200);
      @(posedge clk); #1;
      set_start(0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      void'(exp_q0.pop_back());
      push_cnt[0]--;
      check("t5_bcd", 32'(bcd0), 32'd0);
      check("t5_ovf", 32'(ovf0), 32'd0);
      check("t5_busy", 32'(busy0), 32'd0);
      check("t5_ready", 32'(ready0), 32'd1);
      check("t5_done", 32'(done0), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("t5_no_done", 32'(done_cnt[0]), 32'(push_cnt[0]));
      run_conv(0, 37);
      check("t5_37", 32'(bcd0), 32'h037);

      // T6: start held high, operand changing every cycle
      repeat (3) @(posedge clk);
      #1;
      start0 = 1'b1;
      for (int n = 0; n < 45; n++) begin
         bin0 = 8'($urandom_range(0, 255));
         if (n % 9 == 0) push_exp(0, int'(bin0));
         @(posedge clk); #1;
      end
      start0 = 1'b0;
      repeat (12) @(posedge clk);

      // Legacy range: BIN_W=5, DIGITS=2, sweep 0..31
      for (int i = 0; i < 32; i++) run_conv(2, i);
      repeat (5) @(posedge clk);
      #1;

      // Final accounting
      check("end_q0_empty", 32'(exp_q0.size()), 32'd0);
      check("end_q1_empty", 32'(exp_q1.size()), 32'd0);
      check("end_q2_empty", 32'(exp_q2.size()), 32'd0);
      check("end_done0", 32'(done_cnt[0]), 32'(push_cnt[0]));
      check("end_done1", 32'(done_cnt[1]), 32'(push_cnt[1]));
      check("end_done2", 32'(done_cnt[2]), 32'(push_cnt[2]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
